// File: rtl/fetch_unit_dm_pkg.sv
// Shared definitions for the direct-mapped fetch unit: FSM state type,
// address-split helpers and the NOP encoding.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      MISS = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP = 32'h0000_0000;

   function automatic int unsigned offset_w(input int unsigned words_per_line);
      return $clog2(words_per_line) + 2;
   endfunction

   function automatic int unsigned index_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned words_per_line,
                                         input int unsigned num_lines);
      return addr_w - offset_w(words_per_line) - index_w(num_lines);
   endfunction

endpackage

// File: rtl/fetch_unit_dm_icache.sv
// Direct-mapped I-cache storage: combinational tag/valid/data read,
// synchronous line write, synchronous invalidate-all on rst.
module icache_dm
   import fetch_pkg::*;
#(
   parameter int unsigned NUM_LINES = 16,
   parameter int unsigned TAG_W     = 24,
   parameter int unsigned LINE_W    = 128,
   parameter int unsigned INDEX_W   = index_w(NUM_LINES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [TAG_W-1:0]   rd_tag,
   output logic               rd_hit,
   output logic [LINE_W-1:0]  rd_line,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line
);

   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags [NUM_LINES];
   logic [LINE_W-1:0]    data [NUM_LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[wr_index] <= 1'b1;
      end
   end

   // Tag and data need no reset: valid gates every use of them.
   always_ff @(posedge clk) begin
      if (we) begin
         tags[wr_index] <= wr_tag;
         data[wr_index] <= wr_line;
      end
   end

   assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
   assign rd_line = data[rd_index];

endmodule

// File: rtl/fetch_unit_dm.sv
// Instruction fetch stage with direct-mapped I-cache and line-fill FSM.
// Optional FETCH_PERF_COUNT_EN adds saturating hit_count/miss_count outputs.
module fetch_unit_dm
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W         = 32,
   parameter int unsigned       WORDS_PER_LINE = 4,
   parameter int unsigned       NUM_LINES      = 16,
   parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        redirect_valid,
   input  logic [ADDR_W-1:0]           redirect_target,
   input  logic                        stall,
   output logic [31:0]                 instruction,
   output logic                        instr_valid,
   output logic [ADDR_W-1:0]           pc,
   output logic                        hit,
   output logic                        mem_req,
   output logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_ack,
   input  logic [32*WORDS_PER_LINE-1:0] mem_line
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [31:0]                 hit_count,
   output logic [31:0]                 miss_count
`endif
);

   localparam int unsigned OFFSET_W = offset_w(WORDS_PER_LINE);
   localparam int unsigned INDEX_W  = index_w(NUM_LINES);
   localparam int unsigned TAG_W    = tag_w(ADDR_W, WORDS_PER_LINE, NUM_LINES);
   localparam int unsigned WSEL_W   = $clog2(WORDS_PER_LINE);
   localparam int unsigned LINE_W   = 32 * WORDS_PER_LINE;

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   pc_r, pc_r_d, pc_next, line_addr;
   logic [31:0]         instr_d, fetch_word;
   logic                valid_d, hit_d, req_d, fill_we, cache_hit;
   logic [ADDR_W-1:0]   pc_d, addr_d;
   logic [LINE_W-1:0]   rd_line;
   logic [WSEL_W-1:0]   word_sel;

   icache_dm #(
      .NUM_LINES (NUM_LINES),
      .TAG_W     (TAG_W),
      .LINE_W    (LINE_W),
      .INDEX_W   (INDEX_W)
   ) u_icache (
      .clk      (clk),
      .rst      (rst),
      .rd_index (pc_r[OFFSET_W +: INDEX_W]),
      .rd_tag   (pc_r[ADDR_W-1 -: TAG_W]),
      .rd_hit   (cache_hit),
      .rd_line  (rd_line),
      .we       (fill_we),
      .wr_index (mem_addr[OFFSET_W +: INDEX_W]),
      .wr_tag   (mem_addr[ADDR_W-1 -: TAG_W]),
      .wr_line  (mem_line)
   );

   assign pc_next   = pc_r + ADDR_W'(4);
   assign line_addr = {pc_r[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   assign word_sel  = pc_r[2 +: WSEL_W];

   always_comb begin
      fetch_word = NOP;
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
         if (word_sel == WSEL_W'(w)) fetch_word = rd_line[w*32 +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         pc_r        <= RESET_PC;
         instruction <= NOP;
         instr_valid <= 1'b0;
         pc          <= RESET_PC + ADDR_W'(4);
         hit         <= 1'b1;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
      end else begin
         state_q     <= state_d;
         pc_r        <= pc_r_d;
         instruction <= instr_d;
         instr_valid <= valid_d;
         pc          <= pc_d;
         hit         <= hit_d;
         mem_req     <= req_d;
         mem_addr    <= addr_d;
      end
   end

   // The fill keeps using mem_addr even when a redirect moves pc_r mid-miss.
   always_comb begin
      state_d = state_q;
      pc_r_d  = pc_r;
      instr_d = instruction;
      valid_d = instr_valid;
      pc_d    = pc;
      hit_d   = hit;
      req_d   = mem_req;
      addr_d  = mem_addr;
      fill_we = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect_valid) begin
               pc_r_d  = redirect_target;
               valid_d = 1'b0;
            end else if (!stall) begin
               if (cache_hit) begin
                  instr_d = fetch_word;
                  pc_d    = pc_next;
                  valid_d = 1'b1;
                  hit_d   = 1'b1;
                  pc_r_d  = pc_next;
               end else begin
                  valid_d = 1'b0;
                  hit_d   = 1'b0;
                  req_d   = 1'b1;
                  addr_d  = line_addr;
                  state_d = MISS;
               end
            end
         end
         MISS: begin
            if (redirect_valid) pc_r_d = redirect_target;
            if (mem_ack) begin
               fill_we = 1'b1;
               req_d   = 1'b0;
               state_d = RUN;
            end
         end
      endcase
   end

`ifdef FETCH_PERF_COUNT_EN
   logic hit_evt, miss_evt;
   assign hit_evt  = (state_q == RUN) && !redirect_valid && !stall && cache_hit;
   assign miss_evt = (state_q == RUN) && !redirect_valid && !stall && !cache_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_evt && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
         if (miss_evt && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit_dm.sv
// Self-checking bench for fetch_unit_dm: cold-start vector table, directed
// corner sequences, then randomized traffic against a line-address cache model.
module tb_fetch_unit_dm;

   localparam int unsigned NL = 16;
   localparam logic [31:0] LINE_BYTES = 32'd16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         redirect_valid = 1'b0;
   logic [31:0]  redirect_target = '0;
   logic         stall = 1'b0;
   logic         mem_ack = 1'b0;
   logic [127:0] mem_line = '0;
   logic [31:0]  instruction, pc, mem_addr;
   logic         instr_valid, hit, mem_req;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0]  hit_count, miss_count;
   int unsigned  m_hits, m_misses;
`endif

   fetch_unit_dm #(
      .ADDR_W         (32),
      .WORDS_PER_LINE (4),
      .NUM_LINES      (16),
      .RESET_PC       (32'h0000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .stall           (stall),
      .instruction     (instruction),
      .instr_valid     (instr_valid),
      .pc              (pc),
      .hit             (hit),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_line        (mem_line)
`ifdef FETCH_PERF_COUNT_EN
      ,
      .hit_count       (hit_count),
      .miss_count      (miss_count)
`endif
   );

   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference model: cache tracked as resident line base address per set;
   // instruction memory is static, so a hit returns memword(pc).
   bit          m_vld  [NL];
   logic [31:0] m_base [NL];
   logic [31:0] m_pc, m_instr, m_pcout, m_maddr;
   logic        m_valid, m_hit, m_req;

   int unsigned cnt = 0, lat = 3, fills = 0;
   bit          rand_lat = 1'b0;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [127:0] build_line(input logic [31:0] base);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = memword(base + 32'(4*i));
      return l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int unsigned idx;
      logic [31:0] base;
      if (rst) begin
         for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
         m_pc = '0; m_instr = '0; m_valid = 1'b0; m_pcout = 32'h4;
         m_hit = 1'b1; m_req = 1'b0; m_maddr = '0;
`ifdef FETCH_PERF_COUNT_EN
         m_hits = 0; m_misses = 0;
`endif
      end else if (!m_req) begin
         if (redirect_valid) begin
            m_pc = redirect_target;
            m_valid = 1'b0;
         end else if (!stall) begin
            base = m_pc & ~(LINE_BYTES - 32'd1);
            idx  = (m_pc / LINE_BYTES) % NL;
            if (m_vld[idx] && m_base[idx] == base) begin
               m_instr = memword(m_pc); m_valid = 1'b1; m_pcout = m_pc + 32'd4;
               m_hit = 1'b1; m_pc = m_pc + 32'd4;
`ifdef FETCH_PERF_COUNT_EN
               m_hits++;
`endif
            end else begin
               m_valid = 1'b0; m_hit = 1'b0; m_req = 1'b1; m_maddr = base;
`ifdef FETCH_PERF_COUNT_EN
               m_misses++;
`endif
            end
         end
      end else begin
         if (redirect_valid) m_pc = redirect_target;
         if (mem_ack) begin
            idx = (m_maddr / LINE_BYTES) % NL;
            m_vld[idx] = 1'b1; m_base[idx] = m_maddr; m_req = 1'b0;
         end
      end
   endtask

   task automatic compare_model();
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("pc", pc, m_pcout);
      check("hit", 32'(hit), 32'(m_hit));
      check("mem_req", 32'(mem_req), 32'(m_req));
      check("mem_addr", mem_addr, m_maddr);
      check("instruction", instruction, m_instr);
`ifdef FETCH_PERF_COUNT_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
   endtask

   // One clock: drive inputs plus the memory responder, then check after the edge.
   task automatic step(input logic r, input logic rv, input logic [31:0] tgt,
                       input logic st, input logic fa);
      rst = r; redirect_valid = rv; redirect_target = tgt; stall = st;
      if (r) begin
         cnt = 0; mem_ack = 1'b0;
      end else if (fa) begin
         mem_ack = 1'b1; mem_line = {4{32'hDEAD_BEEF}};
      end else if (m_req && cnt >= lat) begin
         mem_ack = 1'b1; mem_line = build_line(m_maddr); cnt = 0; fills++;
         if (rand_lat) lat = $urandom_range(0, 5);
      end else begin
         mem_ack = 1'b0;
         if (m_req) cnt++;
      end
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      step(1'b0, 1'b1, tgt, 1'b0, 1'b0);
   endtask

   task automatic wait_fill();
      for (int i = 0; i < 20; i++) begin
         if (!mem_req) break;
         idle();
      end
      check("fill_wait", 32'(mem_req), 32'h0);
   endtask

   typedef struct {
      logic        rst;
      logic        stall;
      logic        ev;
      logic [31:0] epc;
      logic        eh;
      logic        er;
      logic [31:0] ea;
      logic [31:0] ei;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int unsigned f0;
      logic r, rv, st, fa;
      logic [31:0] tgt;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h4,  1'b1, 1'b0, 32'h0,  32'h0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h4,  1'b1, 1'b0, 32'h0,  32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b1, 32'h0,  32'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b1, 32'h0,  32'h0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b1, 32'h0,  32'h0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b1, 32'h0,  32'h0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h4,  1'b0, 1'b0, 32'h0,  32'h0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b1, 1'b0, 32'h0,  memword(32'h0)};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 1'b0, 32'h0,  memword(32'h4)};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 1'b0, 32'h0,  memword(32'h8)};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  memword(32'hC)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h10, memword(32'hC)};

      // Cold start with a fixed 3-cycle memory latency.
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].rst, 1'b0, 32'h0, tbl[i].stall, 1'b0);
         check($sformatf("cold%0d_valid", i), 32'(instr_valid), 32'(tbl[i].ev));
         check($sformatf("cold%0d_pc", i), pc, tbl[i].epc);
         check($sformatf("cold%0d_hit", i), 32'(hit), 32'(tbl[i].eh));
         check($sformatf("cold%0d_req", i), 32'(mem_req), 32'(tbl[i].er));
         check($sformatf("cold%0d_addr", i), mem_addr, tbl[i].ea);
         check($sformatf("cold%0d_instr", i), instruction, tbl[i].ei);
      end
      check("cold_fills", fills, 32'd1);
      wait_fill();

      // Warm hit after re-redirect into line 0.
      redirect(32'h4);
      check("warm_redir_valid", 32'(instr_valid), 32'h0);
      idle();
      check("warm_valid", 32'(instr_valid), 32'h1);
      check("warm_instr", instruction, memword(32'h4));
      check("warm_pc", pc, 32'h8);
      check("warm_hit", 32'(hit), 32'h1);
      check("warm_req", 32'(mem_req), 32'h0);

      // Stall holds outputs for 4 cycles, then resumes at the next word.
      idle();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         check("stall_pc", pc, 32'hC);
         check("stall_instr", instruction, memword(32'h8));
         check("stall_valid", 32'(instr_valid), 32'h1);
         check("stall_req", 32'(mem_req), 32'h0);
      end
      idle();
      check("resume_instr", instruction, memword(32'hC));
      check("resume_pc", pc, 32'h10);

      // Redirect during a miss: fill of 0x40 completes, then 0x100 misses.
      redirect(32'h40);
      idle();
      check("rm_addr", mem_addr, 32'h40);
      redirect(32'h100);
      for (int i = 0; i < 20; i++) begin
         if (!mem_req) break;
         check("rm_addr_stable", mem_addr, 32'h40);
         check("rm_no_valid", 32'(instr_valid), 32'h0);
         idle();
      end
      idle();
      check("rm_miss_addr", mem_addr, 32'h100);
      check("rm_miss_req", 32'(mem_req), 32'h1);
      check("rm_miss_hit", 32'(hit), 32'h0);
      wait_fill();
      idle();
      check("rm_hit100_instr", instruction, memword(32'h100));
      redirect(32'h40);
      idle();
      check("rm_line40_hit", 32'(hit), 32'h1);
      check("rm_line40_instr", instruction, memword(32'h40));
      check("rm_line40_req", 32'(mem_req), 32'h0);

      // Conflict eviction: 0x100 replaced line 0x000 in set 0.
      f0 = fills;
      redirect(32'h0);
      idle();
      check("evict_hit", 32'(hit), 32'h0);
      check("evict_addr", mem_addr, 32'h0);
      wait_fill();
      check("evict_fills", fills, f0 + 1);

      // PC wrap at the top of the address space.
      redirect(32'hFFFF_FFF8);
      idle();
      check("wrap_addr", mem_addr, 32'hFFFF_FFF0);
      wait_fill();
      idle();
      idle();
      check("wrap_pc", pc, 32'h0);
      check("wrap_instr", instruction, memword(32'hFFFF_FFFC));
      idle();
      check("wrap_hit0", instruction, memword(32'h0));

      // Reset mid-miss, then a stray ack in RUN must not fill anything.
      redirect(32'h200);
      idle();
      check("rmm_req", 32'(mem_req), 32'h1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("rmm_req_drop", 32'(mem_req), 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      check("stray_req", 32'(mem_req), 32'h0);
      idle();
      check("stray_miss_hit", 32'(hit), 32'h0);
      check("stray_miss_req", 32'(mem_req), 32'h1);
      check("stray_miss_addr", mem_addr, 32'h0);
      wait_fill();

      // Randomized traffic against the model.
      rand_lat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 499) == 0);
         rv  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFC0 + (32'($urandom_range(0, 15)) << 2);
         else                            tgt = 32'($urandom_range(0, 255)) << 2;
         st  = ($urandom_range(0, 3) == 0);
         fa  = !m_req && ($urandom_range(0, 19) == 0);
         step(r, rv, tgt, st, fa);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
